// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte-stream command decoder for a register bank (optional REG_BRIDGE_CHECKSUM_EN)
module uart_reg_bridge #(
    parameter int               N_REGS  = 8,
    parameter int               W_REG   = 32,
    parameter logic [W_REG-1:0] RST_VAL = '0,
    parameter int               TIMEOUT = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [7:0]                 tx_byte,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [N_REGS*W_REG-1:0]    regs_flat,
    output logic                       wr_strobe,
    output logic [((N_REGS > 1) ? $clog2(N_REGS) : 1)-1:0] wr_addr
);
    localparam int NB = W_REG / 8;
    localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
`ifdef REG_BRIDGE_CHECKSUM_EN
    localparam int LAST = NB;
`else
    localparam int LAST = NB - 1;
`endif
    localparam logic [3:0]  LAST_B = 4'(LAST);
    localparam logic [3:0]  NB_B   = 4'(NB);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);
    localparam logic [7:0]  ACK    = 8'hA5;
    localparam logic [7:0]  NAK    = 8'h5A;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_COMMIT, RD_SEND, RESP} state_t;
    state_t state, state_nx;

    logic [W_REG-1:0] regs [N_REGS];
    logic [6:0]       addr, addr_d;
    logic [3:0]       cnt, cnt_d;
    logic [31:0]      idle_cnt, idle_cnt_d;
    logic [W_REG-1:0] shbuf, shbuf_d;
    logic [7:0]       csum, csum_d;
    logic             csum_ok, csum_ok_d;
    logic [7:0]       tx_byte_d;
    logic             tx_valid_d, rx_ready_d, wr_strobe_d, commit_we;
    logic [AW-1:0]    wr_addr_d;
    logic             rx_hs, tx_hs, cmd_in_range, addr_in_range;
    logic [W_REG-1:0] rd_word;
    logic [7:0]       rd_xor;

    assign rx_hs         = rx_valid && rx_ready;
    assign tx_hs         = tx_valid && tx_ready;
    // full 7-bit address is compared so high bits never alias into range
    assign cmd_in_range  = ({25'd0, rx_byte[6:0]} < 32'(N_REGS));
    assign addr_in_range = ({25'd0, addr} < 32'(N_REGS));
    assign rd_word       = regs[rx_byte[AW-1:0]];

    always_comb begin
        rd_xor = '0;
        for (int i = 0; i < NB; i++) rd_xor = rd_xor ^ rd_word[i*8 +: 8];
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) regs_flat[i*W_REG +: W_REG] = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (rx_hs) state_nx = rx_byte[7] ? WR_DATA : (cmd_in_range ? RD_SEND : RESP);
            WR_DATA: begin
                if (rx_hs) begin
                    if (cnt == LAST_B) state_nx = WR_COMMIT;
                end else if (TO_LIM != 32'd0 && idle_cnt + 32'd1 >= TO_LIM) begin
                    state_nx = IDLE;
                end
            end
            WR_COMMIT: state_nx = RESP;
            RD_SEND:   if (tx_hs && cnt == LAST_B) state_nx = IDLE;
            RESP:      if (tx_hs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Next values of every registered output and datapath register.
    always_comb begin
        addr_d      = addr;
        cnt_d       = cnt;
        idle_cnt_d  = idle_cnt;
        shbuf_d     = shbuf;
        csum_d      = csum;
        csum_ok_d   = csum_ok;
        tx_byte_d   = tx_byte;
        tx_valid_d  = tx_valid;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr;
        commit_we   = 1'b0;
        rx_ready_d  = (state_nx == IDLE) || (state_nx == WR_DATA);
        unique case (state)
            IDLE: if (rx_hs) begin
                addr_d     = rx_byte[6:0];
                cnt_d      = '0;
                idle_cnt_d = '0;
                csum_ok_d  = 1'b1;
                if (rx_byte[7]) begin
                    shbuf_d = '0;
                    csum_d  = rx_byte;
                end else if (cmd_in_range) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = rd_word[7:0];
                    shbuf_d    = rd_word >> 8;
                    csum_d     = rd_xor;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            WR_DATA: if (rx_hs) begin
                idle_cnt_d = '0;
                cnt_d      = cnt + 4'd1;
                if (cnt < NB_B) begin
                    shbuf_d = (shbuf >> 8) | (W_REG'(rx_byte) << (W_REG - 8));
                    csum_d  = csum ^ rx_byte;
                end else begin
                    csum_ok_d = (rx_byte == csum);
                end
            end else begin
                idle_cnt_d = idle_cnt + 32'd1;
            end
            WR_COMMIT: begin
                tx_valid_d = 1'b1;
                if (addr_in_range && csum_ok) begin
                    commit_we   = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr[AW-1:0];
                    tx_byte_d   = ACK;
                end else begin
                    tx_byte_d   = NAK;
                end
            end
            RD_SEND: if (tx_hs) begin
                if (cnt == LAST_B) begin
                    tx_valid_d = 1'b0;
                end else begin
                    cnt_d     = cnt + 4'd1;
                    tx_byte_d = (cnt + 4'd1 == NB_B) ? csum : shbuf[7:0];
                    shbuf_d   = shbuf >> 8;
                end
            end
            RESP:    if (tx_hs) tx_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= RST_VAL;
            addr      <= '0;
            cnt       <= '0;
            idle_cnt  <= '0;
            shbuf     <= '0;
            csum      <= '0;
            csum_ok   <= 1'b1;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            rx_ready  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            addr      <= addr_d;
            cnt       <= cnt_d;
            idle_cnt  <= idle_cnt_d;
            shbuf     <= shbuf_d;
            csum      <= csum_d;
            csum_ok   <= csum_ok_d;
            tx_byte   <= tx_byte_d;
            tx_valid  <= tx_valid_d;
            rx_ready  <= rx_ready_d;
            wr_strobe <= wr_strobe_d;
            wr_addr   <= wr_addr_d;
            if (commit_we) regs[addr[AW-1:0]] <= shbuf;
        end
    end
endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Parametrised successor of the UART-driven register bank: a byte-stream command decoder that lets a UART host read and write a configurable bank of N_REGS registers, each W_REG bits wide.
- Sits between a UART core's byte interface (rx valid/ready, tx valid/ready) and the design's control registers.
- New relative to the previous generation: ready/valid handshakes on both byte streams, ACK/NAK responses, out-of-range address handling, an inter-byte timeout, and a write strobe.

Parameters:
N_REGS, 8, number of registers; legal range 1..128
W_REG, 32, register width in bits; multiple of 8, range 8..64; NB = W_REG/8 bytes per register
RST_VAL, 0, reset value of every register
TIMEOUT, 100000, idle-cycle limit between bytes of a write frame; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
rx_byte  in  8  received byte from the UART core
rx_valid  in  1  rx_byte is valid
rx_ready  out  1  bridge accepts rx_byte; a byte transfers on a cycle where rx_valid && rx_ready
tx_byte  out  8  byte to transmit
tx_valid  out  1  tx_byte is valid; held with tx_byte stable until tx_ready
tx_ready  in  1  UART core accepts tx_byte
regs_flat  out  N_REGS*W_REG  all registers concatenated; reg i occupies bits [i*W_REG +: W_REG]
wr_strobe  out  1  one-cycle pulse on each committed write
wr_addr  out  max(1,clog2(N_REGS))  address of the last committed write

Behaviour:
- Reset: state=IDLE, all regs=RST_VAL, tx_valid=0, tx_byte=0, wr_strobe=0, wr_addr=0, rx_ready=0 (it rises in IDLE on the first cycle after reset).
- Command byte: bit7=1 means write, bit7=0 means read; bits[6:0] are the address. The address is in range iff addr < N_REGS.
- rx_ready is 1 only in IDLE and WR_DATA. All outputs are registered.
- IDLE: on a command handshake at cycle t:
  - Write -> WR_DATA with byte count 0 and the shift buffer cleared.
  - Read, in range -> snapshot the register; at cycle t+1 tx_valid=1 with tx_byte = byte0 (LSB); go to RD_SEND.
  - Read, out of range -> at t+1 tx_valid=1 with tx_byte=0x5A (NAK); go to RESP.
- WR_DATA: accepts NB data bytes, LSB first. The handshake on the last byte at cycle t -> WR_COMMIT in cycle t+1. At the end of t+1:
  - In range: register updated, wr_strobe=1 for exactly one cycle, wr_addr=addr, tx_byte=0xA5 (ACK).
  - Out of range: no register change, no strobe, tx_byte=0x5A.
  - Either case: tx_valid=1; go to RESP.
- Timeout: a counter clears on every accepted byte in WR_DATA. If it reaches TIMEOUT, return to IDLE, discard the partial frame, and send no response.
- RD_SEND: each tx handshake advances to the next byte; the next byte is presented the cycle after. The handshake on byte NB-1 clears tx_valid the next cycle and returns to IDLE.
- RESP: the tx handshake clears tx_valid the next cycle and returns to IDLE.
- Stalls: tx_ready low for any number of cycles holds tx_byte and tx_valid unchanged. No rx bytes are accepted while RD_SEND or RESP is active; the upstream FIFO buffers them.
- The register snapshot taken for a read is unaffected by later activity. The bridge is the only writer.
- Reset mid-frame: every state and output returns to its reset value immediately, and the partial frame is lost.
- Command address bits above clog2(N_REGS) take part in the range check and are never truncated.

Optional Feature:
- Macro REG_BRIDGE_CHECKSUM_EN.
- Defined:
  - Read responses append one extra byte: the XOR of all NB data bytes.
  - Write frames carry one extra trailing byte: the XOR of the command byte and all data bytes.
  - On a checksum mismatch: no write, no strobe, and a 0x5A response.
  - Out-of-range reads still return the single byte 0x5A.
- Undefined: frames carry no checksum byte; behaviour is exactly as above.

Test Plan:
- Defaults: write cmd 0x83 then bytes 78 56 34 12 -> ACK 0xA5; reg3=0x12345678; one wr_strobe pulse with wr_addr=3; other regs stay 0.
- Read back: cmd 0x03 -> tx bytes 78,56,34,12 in order. Holding tx_ready low for 5 cycles before byte 2 keeps tx_byte=0x34 stable throughout.
- Out of range (N_REGS=8): cmd 0x89 plus 4 bytes -> NAK 0x5A, no strobe, all regs unchanged. Cmd 0x0A -> single byte 0x5A.
- Timeout (TIMEOUT=50): cmd 0x81, bytes AA BB, then 60 idle cycles -> no response, reg1 unchanged. The next cmd 0x01 returns 00 00 00 00.
- W_REG=16, N_REGS=2: write 0x81 EF BE -> ACK, reg1=0xBEEF. Asserting rst_n low mid-frame after cmd 0x80 and one byte -> regs=RST_VAL and tx_valid=0.
- With REG_BRIDGE_CHECKSUM_EN: write 0x82 01 02 03 04 with checksum 0x86 -> ACK; the same frame with checksum 0x00 -> NAK, no write. Read 0x02 -> 01 02 03 04 04.
